// File: rtl/raster_pkg.sv
// Shared raster definitions: fixed-point/colour widths, tile buffer FSM states and far-plane depth.
// The width macros fall back to defaults when the build does not provide them.
`ifndef TILE_AREA_BITS
`define TILE_AREA_BITS 8
`endif
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif
`ifndef COLOR_BITS
`define COLOR_BITS 16
`endif

package raster_pkg;

  localparam int Z_BITS     = 2 * `FX_TOTAL_BITS;
  localparam int COLOR_BITS = `COLOR_BITS;

  // Depth written by the clear pass: the most positive signed value.
  localparam logic signed [Z_BITS-1:0] Z_FAR = {1'b0, {(Z_BITS-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_RENDER = 2'd1,
    ST_FLUSH  = 2'd2
  } tile_buf_state_t;

endpackage

// File: rtl/tile_buffer_if.sv
// Scan-out stream of the tile buffer: valid/ready beats carrying one pixel colour with its
// position in the tile. master = tile buffer, slave = downstream consumer.
interface tile_buffer_if #(
  parameter int AREA_BITS = `TILE_AREA_BITS,
  parameter int COL_BITS  = 4
);

  logic                          flush_vld;
  logic                          flush_rdy;
  logic [`COLOR_BITS-1:0]        flush_color;
  logic [COL_BITS-1:0]           flush_x;
  logic [AREA_BITS-COL_BITS-1:0] flush_y;
  logic                          flush_last;

  modport master (
    output flush_vld, flush_color, flush_x, flush_y, flush_last,
    input  flush_rdy
  );

  modport slave (
    input  flush_vld, flush_color, flush_x, flush_y, flush_last,
    output flush_rdy
  );

endinterface

// File: rtl/tile_ram.sv
// 1R1W synchronous memory with registered read and write-first bypass on an address match.
// The read register holds its value while re is low.
module tile_ram #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdata_reg;

  // The array itself carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/tile_buffer.sv
// On-chip tile colour/depth buffer: clears itself, serves render reads/writes, then streams the
// tile out. Define TILE_BUFFER_ZBUF_EN to build the depth storage; otherwise depth reads return Z_FAR.
module tile_buffer
  import raster_pkg::*;
#(
  parameter int AREA_BITS = `TILE_AREA_BITS,
  parameter int COL_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         z_write_en,
  input  logic [AREA_BITS-1:0]         z_write_addr,
  input  logic signed [Z_BITS-1:0]     z_data_in,
  input  logic [AREA_BITS-1:0]         z_read_addr,
  output logic signed [Z_BITS-1:0]     z_data_out,

  input  logic                         color_write_en,
  input  logic [AREA_BITS-1:0]         color_write_addr,
  input  logic [COLOR_BITS-1:0]        color_data_in,
  input  logic [AREA_BITS-1:0]         color_read_addr,
  output logic [COLOR_BITS-1:0]        color_data_out,

  output logic                         render_rdy,
  input  logic                         flush_req,
  tile_buffer_if.master                flush_if
);

  localparam logic [AREA_BITS-1:0] ADDR_MAX = '1;

  tile_buf_state_t state_reg, state_next;

  logic [AREA_BITS-1:0]  clear_addr_reg;
  logic [AREA_BITS-1:0]  fetch_addr_reg;
  logic                  fetch_done_reg;
  logic                  s1_vld_reg;
  logic [AREA_BITS-1:0]  s1_addr_reg;
  logic                  out_vld_reg;
  logic [COLOR_BITS-1:0] out_color_reg;
  logic [COL_BITS-1:0]   out_x_reg;
  logic [AREA_BITS-COL_BITS-1:0] out_y_reg;
  logic                  out_last_reg;

  logic                  advance;
  logic                  fetch_issue;
  logic                  last_accept;

  logic                  color_we;
  logic [AREA_BITS-1:0]  color_waddr;
  logic [COLOR_BITS-1:0] color_wdata;
  logic                  color_re;
  logic [AREA_BITS-1:0]  color_raddr;
  logic [COLOR_BITS-1:0] color_rdata;

  // Scan-out pipeline: RAM read register (s1) feeding the output register.
  assign advance     = !out_vld_reg || flush_if.flush_rdy;
  assign fetch_issue = (state_reg == ST_FLUSH) && !fetch_done_reg && (!s1_vld_reg || advance);
  assign last_accept = out_vld_reg && flush_if.flush_rdy && out_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_CLEAR;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR:  if (clear_addr_reg == ADDR_MAX) state_next = ST_RENDER;
      ST_RENDER: if (flush_req)                  state_next = ST_FLUSH;
      ST_FLUSH:  if (last_accept)                state_next = ST_CLEAR;
      default:                                   state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    render_rdy  = 1'b0;
    color_we    = 1'b0;
    color_waddr = clear_addr_reg;
    color_wdata = '0;
    color_re    = 1'b0;
    color_raddr = color_read_addr;
    case (state_reg)
      ST_CLEAR: begin
        color_we = 1'b1;
      end
      ST_RENDER: begin
        render_rdy  = 1'b1;
        color_we    = color_write_en;
        color_waddr = color_write_addr;
        color_wdata = color_data_in;
        color_re    = 1'b1;
      end
      ST_FLUSH: begin
        color_re    = fetch_issue;
        color_raddr = fetch_addr_reg;
      end
      default: ;
    endcase
  end

  // Clear counter saturates at the last entry and restarts when a flush hands back to CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_addr_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      if (clear_addr_reg != ADDR_MAX) clear_addr_reg <= clear_addr_reg + AREA_BITS'(1);
    end else if (state_next == ST_CLEAR) begin
      clear_addr_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_reg <= '0;
      fetch_done_reg <= 1'b0;
      s1_vld_reg     <= 1'b0;
      s1_addr_reg    <= '0;
      out_vld_reg    <= 1'b0;
      out_color_reg  <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_last_reg   <= 1'b0;
    end else if (state_reg != ST_FLUSH) begin
      fetch_addr_reg <= '0;
      fetch_done_reg <= 1'b0;
      s1_vld_reg     <= 1'b0;
      out_vld_reg    <= 1'b0;
      out_last_reg   <= 1'b0;
    end else begin
      if (fetch_issue) begin
        if (fetch_addr_reg == ADDR_MAX) fetch_done_reg <= 1'b1;
        else                            fetch_addr_reg <= fetch_addr_reg + AREA_BITS'(1);
      end
      if (advance) begin
        out_vld_reg <= s1_vld_reg;
        if (s1_vld_reg) begin
          out_color_reg <= color_rdata;
          out_x_reg     <= s1_addr_reg[COL_BITS-1:0];
          out_y_reg     <= s1_addr_reg[AREA_BITS-1:COL_BITS];
          out_last_reg  <= (s1_addr_reg == ADDR_MAX);
        end
      end
      if (fetch_issue) begin
        s1_vld_reg  <= 1'b1;
        s1_addr_reg <= fetch_addr_reg;
      end else if (advance) begin
        s1_vld_reg  <= 1'b0;
      end
    end
  end

  assign flush_if.flush_vld   = out_vld_reg;
  assign flush_if.flush_color = out_color_reg;
  assign flush_if.flush_x     = out_x_reg;
  assign flush_if.flush_y     = out_y_reg;
  assign flush_if.flush_last  = out_last_reg;

  tile_ram #(.ADDR_BITS(AREA_BITS), .DATA_BITS(COLOR_BITS)) u_color_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (color_we),
    .waddr (color_waddr),
    .wdata (color_wdata),
    .re    (color_re),
    .raddr (color_raddr),
    .rdata (color_rdata)
  );

  assign color_data_out = color_rdata;

`ifdef TILE_BUFFER_ZBUF_EN
  logic                 z_we;
  logic [AREA_BITS-1:0] z_waddr;
  logic [Z_BITS-1:0]    z_wdata;
  logic [Z_BITS-1:0]    z_rdata;

  assign z_we    = (state_reg == ST_CLEAR) || (render_rdy && z_write_en);
  assign z_waddr = render_rdy ? z_write_addr : clear_addr_reg;
  assign z_wdata = render_rdy ? z_data_in : Z_FAR;

  tile_ram #(.ADDR_BITS(AREA_BITS), .DATA_BITS(Z_BITS)) u_z_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (z_we),
    .waddr (z_waddr),
    .wdata (z_wdata),
    .re    (render_rdy),
    .raddr (z_read_addr),
    .rdata (z_rdata)
  );

  assign z_data_out = z_rdata;
`else
  logic signed [Z_BITS-1:0] z_out_reg;
  logic                     unused_z;

  // No depth storage: every render read answers with the far plane one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      z_out_reg <= '0;
    else if (state_reg == ST_RENDER) z_out_reg <= Z_FAR;
  end

  assign z_data_out = z_out_reg;
  assign unused_z   = ^{z_write_en, z_write_addr, z_data_in, z_read_addr};
`endif

endmodule

// File: tb/tb_tile_buffer.sv
// Directed bench for tile_buffer: clear timing, render read/write/bypass, full and stalled
// scan-out, reset during scan-out. Depth expectations follow TILE_BUFFER_ZBUF_EN.
module tb_tile_buffer;

`ifdef TILE_BUFFER_ZBUF_EN
  localparam bit ZBUF = 1'b1;
`else
  localparam bit ZBUF = 1'b0;
`endif

  localparam logic signed [31:0] ZFAR = 32'sh7FFF_FFFF;

  logic               clk;
  logic               rst_n;
  logic               z_write_en;
  logic [7:0]         z_write_addr;
  logic signed [31:0] z_data_in;
  logic [7:0]         z_read_addr;
  logic signed [31:0] z_data_out;
  logic               color_write_en;
  logic [7:0]         color_write_addr;
  logic [15:0]        color_data_in;
  logic [7:0]         color_read_addr;
  logic [15:0]        color_data_out;
  logic               render_rdy;
  logic               flush_req;

  int errors = 0;
  int checks = 0;

  tile_buffer_if #(.AREA_BITS(8), .COL_BITS(4)) fif ();

  tile_buffer #(.AREA_BITS(8), .COL_BITS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .z_write_en       (z_write_en),
    .z_write_addr     (z_write_addr),
    .z_data_in        (z_data_in),
    .z_read_addr      (z_read_addr),
    .z_data_out       (z_data_out),
    .color_write_en   (color_write_en),
    .color_write_addr (color_write_addr),
    .color_data_in    (color_data_in),
    .color_read_addr  (color_read_addr),
    .color_data_out   (color_data_out),
    .render_rdy       (render_rdy),
    .flush_req        (flush_req),
    .flush_if         (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    z_write_en = 0; z_write_addr = 0; z_data_in = 0; z_read_addr = 0;
    color_write_en = 0; color_write_addr = 0; color_data_in = 0; color_read_addr = 0;
    flush_req = 0; fif.flush_rdy = 0;
  endtask

  task automatic wait_render(input int budget, output int cycles);
    cycles = 0;
    while (!render_rdy && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic fill_colors(input logic [15:0] base);
    for (int a = 0; a < 256; a++) begin
      color_write_en   = 1'b1;
      color_write_addr = a[7:0];
      color_data_in    = base + a[15:0];
      @(negedge clk);
    end
    color_write_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int total;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({render_rdy, fif.flush_vld, fif.flush_last} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {render_rdy, fif.flush_vld, fif.flush_last});
    end
    checks++;
    if (color_data_out !== 16'h0 || z_data_out !== 32'sh0) begin
      errors++; $display("FAIL reset_rdata: got color %h z %h expected 0 0", color_data_out, z_data_out);
    end
    checks++;
    if ({fif.flush_color, fif.flush_x, fif.flush_y} !== 24'h0) begin
      errors++; $display("FAIL reset_flush_data: got %h expected 0", {fif.flush_color, fif.flush_x, fif.flush_y});
    end
    rst_n = 1'b1;
    total = 0;
    repeat (10) begin @(negedge clk); total++; end
    flush_req = 1'b1;
    @(negedge clk); total++;
    flush_req = 1'b0;
    wait_render(400, n);
    total += n;
    checks++;
    if (total !== 256) begin
      errors++; $display("FAIL clear_latency: got %0d cycles expected 256", total);
    end
    @(negedge clk);
    checks++;
    if ({render_rdy, fif.flush_vld} !== 2'b10) begin
      errors++; $display("FAIL req_in_clear: got rdy/vld %b expected 10", {render_rdy, fif.flush_vld});
    end
    $display("reset: clear took %0d cycles", total);
  endtask

  task automatic test_clear_values();
    color_read_addr = 8'h3C;
    z_read_addr     = 8'h3C;
    @(negedge clk);
    checks++;
    if (color_data_out !== 16'h0 || z_data_out !== ZFAR) begin
      errors++; $display("FAIL clear_read_3c: got color %h z %h expected 0000 7fffffff", color_data_out, z_data_out);
    end
    $display("clear_values: addr 3c color %h z %h", color_data_out, z_data_out);
  endtask

  task automatic test_write_read();
    logic signed [31:0] exp_z;
    z_write_en = 1; z_write_addr = 8'd5; z_data_in = 32'sh100;
    color_write_en = 1; color_write_addr = 8'd7; color_data_in = 16'hABCD; color_read_addr = 8'd7;
    @(negedge clk);
    z_write_en = 0; color_write_en = 0; z_read_addr = 8'd5;
    checks++;
    if (color_data_out !== 16'hABCD) begin
      errors++; $display("FAIL color_bypass: got %h expected abcd", color_data_out);
    end
    @(negedge clk);
    exp_z = ZBUF ? 32'sh100 : ZFAR;
    checks++;
    if (z_data_out !== exp_z) begin
      errors++; $display("FAIL z_write_read5: got %h expected %h", z_data_out, exp_z);
    end
    z_write_en = 1; z_write_addr = 8'd3; z_data_in = 32'sh10;
    @(negedge clk);
    z_write_en = 0; z_read_addr = 8'd3;
    @(negedge clk);
    exp_z = ZBUF ? 32'sh10 : ZFAR;
    checks++;
    if (z_data_out !== exp_z || color_data_out !== 16'hABCD) begin
      errors++; $display("FAIL z_read3_color7: got z %h color %h expected %h abcd", z_data_out, color_data_out, exp_z);
    end
    z_write_en = 1; z_write_addr = 8'd9; z_data_in = -32'sd5; z_read_addr = 8'd9;
    @(negedge clk);
    z_write_en = 0;
    exp_z = ZBUF ? -32'sd5 : ZFAR;
    checks++;
    if (z_data_out !== exp_z) begin
      errors++; $display("FAIL z_bypass9: got %h expected %h", z_data_out, exp_z);
    end
    $display("write_read: z5/z3/z9 and color7 done");
  endtask

  task automatic test_flush_full();
    int idx;
    int cyc;
    int lasts;
    int n;
    logic [24:0] exp_beat;
    fill_colors(16'h0000);
    fif.flush_rdy = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    checks++;
    if ({render_rdy, fif.flush_vld} !== 2'b00) begin
      errors++; $display("FAIL flush_enter: got rdy/vld %b expected 00", {render_rdy, fif.flush_vld});
    end
    @(negedge clk);
    checks++;
    if (fif.flush_vld !== 1'b0) begin
      errors++; $display("FAIL flush_early_vld: got %b expected 0", fif.flush_vld);
    end
    @(negedge clk);
    checks++;
    if (fif.flush_vld !== 1'b1) begin
      errors++; $display("FAIL flush_first_vld: got %b expected 1", fif.flush_vld);
    end
    idx = 0; cyc = 0; lasts = 0;
    while (idx < 256 && cyc < 600) begin
      if (fif.flush_vld) begin
        exp_beat = {idx[15:0], idx[3:0], idx[7:4], (idx == 255)};
        lasts += int'(fif.flush_last);
        checks++;
        if ({fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last} !== exp_beat) begin
          errors++; $display("FAIL flush_beat_%0d: got %h expected %h", idx,
                             {fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last}, exp_beat);
        end
        if (idx == 8'h5A) begin
          checks++;
          if ({fif.flush_x, fif.flush_y, fif.flush_color} !== 24'hA5_005A) begin
            errors++; $display("FAIL beat_5a: got x %h y %h color %h expected a 5 005a",
                               fif.flush_x, fif.flush_y, fif.flush_color);
          end
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (idx !== 256 || lasts !== 1) begin
      errors++; $display("FAIL flush_count: got %0d beats %0d lasts expected 256 1", idx, lasts);
    end
    checks++;
    if ({fif.flush_vld, render_rdy} !== 2'b00) begin
      errors++; $display("FAIL flush_exit: got vld/rdy %b expected 00", {fif.flush_vld, render_rdy});
    end
    wait_render(400, n);
    checks++;
    if (n + 1 !== 257) begin
      errors++; $display("FAIL post_flush_clear: got %0d cycles expected 257", n + 1);
    end
    color_read_addr = 8'h5A;
    @(negedge clk);
    checks++;
    if (color_data_out !== 16'h0) begin
      errors++; $display("FAIL post_flush_read: got %h expected 0000", color_data_out);
    end
    $display("flush_full: %0d beats, clear %0d cycles", idx, n + 1);
  endtask

  task automatic test_flush_stall();
    int idx;
    int cyc;
    int n;
    bit stalled;
    logic [24:0] held;
    logic [24:0] exp_beat;
    fill_colors(16'h1000);
    fif.flush_rdy = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    idx = 0; cyc = 0; stalled = 0; held = '0;
    while (idx < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if (fif.flush_vld !== 1'b1 ||
            {fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last} !== held) begin
          errors++; $display("FAIL stall_hold_%0d: got vld %b data %h expected 1 %h", idx, fif.flush_vld,
                             {fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last}, held);
        end
        stalled = 0;
      end
      fif.flush_rdy = cyc[0];
      if (fif.flush_vld) begin
        if (fif.flush_rdy) begin
          exp_beat = {16'h1000 + idx[15:0], idx[3:0], idx[7:4], (idx == 255)};
          checks++;
          if ({fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last} !== exp_beat) begin
            errors++; $display("FAIL stall_beat_%0d: got %h expected %h", idx,
                               {fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last}, exp_beat);
          end
          idx++;
        end else begin
          held = {fif.flush_color, fif.flush_x, fif.flush_y, fif.flush_last};
          stalled = 1;
        end
      end
    end
    fif.flush_rdy = 1'b1;
    checks++;
    if (idx !== 256) begin
      errors++; $display("FAIL stall_count: got %0d beats expected 256", idx);
    end
    wait_render(600, n);
    checks++;
    if (render_rdy !== 1'b1) begin
      errors++; $display("FAIL stall_return: got render_rdy %b expected 1", render_rdy);
    end
    $display("flush_stall: %0d beats in %0d cycles", idx, cyc);
  endtask

  task automatic test_reset_mid_flush();
    int idx;
    int cyc;
    int n;
    logic [7:0] probe [4];
    probe = '{8'h00, 8'h64, 8'h3C, 8'hFF};
    fill_colors(16'h2000);
    fif.flush_rdy = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (fif.flush_vld) idx++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fif.flush_vld, render_rdy} !== 2'b00) begin
      errors++; $display("FAIL midflush_reset: got vld/rdy %b expected 00", {fif.flush_vld, render_rdy});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fif.flush_vld !== 1'b0) begin
      errors++; $display("FAIL midflush_held: got vld %b expected 0", fif.flush_vld);
    end
    rst_n = 1'b1;
    wait_render(400, n);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL midflush_clear: got %0d cycles expected 256", n);
    end
    for (int i = 0; i < 4; i++) begin
      color_read_addr = probe[i];
      z_read_addr     = probe[i];
      @(negedge clk);
      checks++;
      if (color_data_out !== 16'h0 || z_data_out !== ZFAR) begin
        errors++; $display("FAIL midflush_read_%h: got color %h z %h expected 0000 7fffffff",
                           probe[i], color_data_out, z_data_out);
      end
    end
    $display("reset_mid_flush: reset at beat %0d, clear %0d cycles", idx, n);
  endtask

  initial begin
    test_reset();
    test_clear_values();
    test_write_read();
    test_flush_full();
    test_flush_stall();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
